// File: rtl/rom_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-read-port pattern ROM.
// Accepts one request per cycle and returns data on a fixed 2-cycle pipeline.
module rom_port_arbiter #(
    parameter int DATA_W   = 10,
    parameter int ADDR_W   = 11,
    parameter int MAX_ADDR = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

    // Arbitration state: rr pointer and the port accepted in the previous cycle.
    logic              rr_q, rr_d;
    logic              own_vld_q, own_vld_d;
    logic              own_id_q, own_id_d;

    // Stage A (ROM access) and stage B (response).
    logic              a_vld_q, a_vld_d;
    logic              a_port_q, a_port_d;
    logic              a_err_q, a_err_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              own_hold;
    logic              accept;
    logic              win_id;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_lock;
    logic              oor;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        own_hold = own_vld_q && (own_id_q ? (lock1 && req1) : (lock0 && req0));
        if (rst_n) begin
            if (own_hold) begin
                gnt0 = ~own_id_q;
                gnt1 = own_id_q;
            end else if (req0 && req1) begin
                gnt0 = ~rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end

        accept   = gnt0 | gnt1;
        win_id   = gnt1;
        sel_addr = win_id ? addr1 : addr0;
        sel_lock = win_id ? lock1 : lock0;
        oor      = sel_addr > MAX_A;

        // A locked accept keeps the pointer where it is so the burst owner stays favoured.
        rr_d      = (accept && !sel_lock) ? ~win_id : rr_q;
        own_vld_d = accept;
        own_id_d  = win_id;

        a_vld_d    = accept;
        a_port_d   = win_id;
        a_err_d    = accept && oor;
        rom_en_d   = accept && !oor;
        rom_addr_d = (accept && !oor) ? sel_addr : '0;

        rvalid0_d = a_vld_q && !a_port_q;
        rvalid1_d = a_vld_q && a_port_q;
        err_d     = a_vld_q && a_err_q;
        rdata_d   = rdata_q;
        if (a_vld_q) begin
            rdata_d = a_err_q ? '0 : rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b0;
            own_vld_q  <= 1'b0;
            own_id_q   <= 1'b0;
            a_vld_q    <= 1'b0;
            a_port_q   <= 1'b0;
            a_err_q    <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rr_q       <= rr_d;
            own_vld_q  <= own_vld_d;
            own_id_q   <= own_id_d;
            a_vld_q    <= a_vld_d;
            a_port_q   <= a_port_d;
            a_err_q    <= a_err_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign err      = err_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed grant table, reset and
// sweep sequences, random traffic, all checked against a cycle-indexed model.
module tb_rom_port_arbiter;

    localparam int DATA_W   = 10;
    localparam int ADDR_W   = 11;
    localparam int MAX_ADDR = 1023;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, err, rom_en;
    logic [DATA_W-1:0] rdata, rom_data;
    logic [ADDR_W-1:0] rom_addr;

    rom_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .err(err), .rdata(rdata),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a * 11'd37 + 11'd101;
        return t[9:0] ^ a[10:1];
    endfunction

    assign rom_data = rom_val(rom_addr);

    int errors = 0;
    int checks = 0;

    // Reference model: favoured port, last owner, and accepted requests indexed by cycle.
    int fav;
    int owner;
    int cyc;
    bit slot_v[8];
    int slot_p[8];
    int slot_a[8];
    logic [DATA_W-1:0] last_rdata;
    int n_rv0;

    typedef struct {
        bit r0, r1, l0, l1;
        int a0, a1;
        bit g0, g1;
    } vec_t;
    vec_t tbl[28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        fav = 0;
        owner = -1;
        for (int i = 0; i < 8; i++) slot_v[i] = 1'b0;
        last_rdata = '0;
    endtask

    task automatic check_regs();
        int r, s;
        bit rv, e;
        logic [DATA_W-1:0] d;
        r  = (cyc - 1) % 8;
        s  = (cyc - 2) % 8;
        rv = slot_v[r] && (slot_a[r] <= MAX_ADDR);
        chk("rom_en", {31'b0, rom_en}, {31'b0, rv});
        chk("rom_addr", {21'b0, rom_addr}, rv ? slot_a[r] : 0);
        if (rvalid0 === 1'b1) n_rv0++;
        if (slot_v[s]) begin
            e = slot_a[s] > MAX_ADDR;
            d = e ? '0 : rom_val(ADDR_W'(slot_a[s]));
            last_rdata = d;
            chk("rvalid0", {31'b0, rvalid0}, {31'b0, slot_p[s] == 0});
            chk("rvalid1", {31'b0, rvalid1}, {31'b0, slot_p[s] == 1});
            chk("err", {31'b0, err}, {31'b0, e});
            chk("rdata", {22'b0, rdata}, {22'b0, d});
        end else begin
            chk("rvalid0_idle", {31'b0, rvalid0}, 0);
            chk("rvalid1_idle", {31'b0, rvalid1}, 0);
            chk("err_idle", {31'b0, err}, 0);
            chk("rdata_hold", {22'b0, rdata}, {22'b0, last_rdata});
        end
    endtask

    // Grant rule: a locked owner that still requests keeps the port, otherwise the favoured requester wins.
    task automatic model_grant(output int win);
        bit rq[2];
        bit lk[2];
        rq[0] = req0; rq[1] = req1;
        lk[0] = lock0; lk[1] = lock1;
        win = -1;
        if (owner >= 0 && lk[owner] && rq[owner]) win = owner;
        else if (rq[fav]) win = fav;
        else if (rq[1 - fav]) win = 1 - fav;
        slot_v[cyc % 8] = (win >= 0);
        slot_p[cyc % 8] = win;
        slot_a[cyc % 8] = (win == 1) ? int'(addr1) : int'(addr0);
        if (win >= 0 && !lk[win]) fav = 1 - win;
        owner = win;
        cyc++;
    endtask

    task automatic do_cycle(input bit r0, input bit r1, input bit l0, input bit l1,
                            input int a0, input int a1, input int tg0, input int tg1);
        int win;
        check_regs();
        req0 = r0; req1 = r1; lock0 = l0; lock1 = l1;
        addr0 = ADDR_W'(a0); addr1 = ADDR_W'(a1);
        #1;
        model_grant(win);
        chk("gnt0", {31'b0, gnt0}, {31'b0, win == 0});
        chk("gnt1", {31'b0, gnt1}, {31'b0, win == 1});
        if (tg0 >= 0) chk("tbl_gnt0", {31'b0, gnt0}, tg0);
        if (tg1 >= 0) chk("tbl_gnt1", {31'b0, gnt1}, tg1);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rom_en"}, {31'b0, rom_en}, 0);
        chk({tag, "_rom_addr"}, {21'b0, rom_addr}, 0);
        chk({tag, "_rvalid0"}, {31'b0, rvalid0}, 0);
        chk({tag, "_rvalid1"}, {31'b0, rvalid1}, 0);
        chk({tag, "_err"}, {31'b0, err}, 0);
        chk({tag, "_rdata"}, {22'b0, rdata}, 0);
        chk({tag, "_gnt0"}, {31'b0, gnt0}, 0);
        chk({tag, "_gnt1"}, {31'b0, gnt1}, 0);
    endtask

    initial begin
        //           r0 r1 l0 l1  a0    a1    g0 g1
        tbl[0]  = '{1, 0, 0, 0,    5,    0, 1, 0};
        tbl[1]  = '{0, 0, 0, 0,    5,    0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0,    5,    0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0,    0, 1024, 0, 1};
        tbl[4]  = '{0, 0, 0, 0,    0, 1024, 0, 0};
        tbl[5]  = '{0, 0, 0, 0,    0, 1024, 0, 0};
        tbl[6]  = '{0, 1, 0, 0,    0, 1023, 0, 1};
        for (int i = 0; i < 8; i++) tbl[7 + i] = '{1, 1, 0, 0, 10, 20, (i % 2) == 0, (i % 2) == 1};
        for (int i = 0; i < 4; i++) tbl[15 + i] = '{1, 1, 1, 0, 30, 40, 1, 0};
        tbl[19] = '{0, 1, 0, 0,   30,   40, 0, 1};
        tbl[20] = '{1, 1, 0, 1,   50,   60, 0, 1};
        tbl[21] = '{1, 1, 0, 0,   50,   60, 1, 0};
        tbl[22] = '{0, 0, 0, 0,   50,   60, 0, 0};
        tbl[23] = '{1, 1, 1, 0,   70,   80, 0, 1};
        tbl[24] = '{1, 1, 1, 0,   70,   80, 1, 0};
        tbl[25] = '{1, 1, 1, 0,   70,   80, 1, 0};
        tbl[26] = '{0, 0, 0, 0,    0,    0, 0, 0};
        tbl[27] = '{0, 0, 0, 0,    0,    0, 0, 0};

        // Power-on reset with requests pending: grants must stay low.
        model_clear();
        cyc = 2;
        n_rv0 = 0;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        rst_n = 1'b1;

        foreach (tbl[i])
            do_cycle(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, tbl[i].a0, tbl[i].a1,
                     int'(tbl[i].g0), int'(tbl[i].g1));

        // Asynchronous reset with two accesses in flight.
        do_cycle(1, 1, 0, 0, 100, 200, -1, -1);
        do_cycle(1, 1, 0, 0, 101, 201, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        check_reset_state("rst_hold");
        rst_n = 1'b1;
        model_clear();
        do_cycle(1, 1, 0, 0, 300, 400, 1, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic, including out-of-range addresses and locks.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, 1100)), int'($urandom_range(0, 1100)), -1, -1);
        end
        do_cycle(0, 0, 0, 0, 0, 0, -1, -1);
        do_cycle(0, 0, 0, 0, 0, 0, -1, -1);

        // Full-address sweep from port 0, one accept per cycle.
        n_rv0 = 0;
        for (int a = 0; a <= MAX_ADDR; a++) do_cycle(1, 0, 0, 0, a, 0, 1, 0);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sweep_count", n_rv0, MAX_ADDR + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
